// File: rtl/instr_fetch.sv
// Instruction fetch unit: loads a 16x9 program store, then issues instructions over valid/ready.
// Optional macro FETCH_PREFETCH_EN enables the one-entry prefetch path (1 instruction/cycle).
module instr_fetch (
    input  logic       clk,
    input  logic       rst,
    input  logic       pmode,
    input  logic       prog_we,
    input  logic [8:0] prog_data,
    output logic [8:0] instout,
    output logic       inst_valid,
    input  logic       inst_ready,
    input  logic       jump_en,
    input  logic [3:0] jump_addr,
    output logic [3:0] pc,
    output logic       prog_full,
    output logic       halt
);

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, ISSUE, HALT} state_t;

    state_t     r_state, w_state_nxt;
    logic [8:0] r_mem [16];
    logic [4:0] r_count, w_count_nxt;
    logic [3:0] r_pc, w_pc_nxt;
    logic [8:0] r_instr, w_instr_nxt;
    logic       r_pmode;

    logic       w_rise;
    logic       w_fall;
    logic       w_we;
    logic       w_xfer;
    logic       w_seq_end;
    logic [3:0] w_pc_inc;
    logic [4:0] w_pc_inc_wide;

    assign w_rise        = pmode & ~r_pmode;
    assign w_fall        = ~pmode & r_pmode;
    // A write coinciding with the pmode fall still lands, so only the state gates it.
    assign w_we          = (r_state == LOAD) & prog_we & (r_count < 5'd16);
    assign w_xfer        = (r_state == ISSUE) & inst_ready;
    assign w_pc_inc      = r_pc + 4'd1;
    assign w_pc_inc_wide = {1'b0, r_pc} + 5'd1;
    assign w_seq_end     = (w_pc_inc_wide >= r_count);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        case (r_state)
            IDLE: begin
                if (pmode) begin
                    w_state_nxt = LOAD;
                    w_count_nxt = 5'd0;
                end
            end
            LOAD: begin
                if (w_we) begin
                    w_count_nxt = r_count + 5'd1;
                end
                if (w_fall) begin
                    w_pc_nxt    = 4'd0;
                    w_state_nxt = (w_count_nxt == 5'd0) ? HALT : FETCH;
                end
            end
            FETCH: begin
                w_instr_nxt = r_mem[r_pc];
                w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (w_xfer) begin
                    if (r_instr == 9'd0) begin
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = HALT;
                    end else if (jump_en) begin
                        // Jumps flush any prefetched word and refetch the target.
                        w_pc_nxt    = jump_addr;
                        w_state_nxt = FETCH;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                        if (w_seq_end) begin
                            w_state_nxt = HALT;
                        end else begin
`ifdef FETCH_PREFETCH_EN
                            w_instr_nxt = r_mem[w_pc_inc];
                            w_state_nxt = ISSUE;
`else
                            w_state_nxt = FETCH;
`endif
                        end
                    end
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // A new load session overrides whatever was in flight, including a pending issue.
        if (w_rise) begin
            w_state_nxt = LOAD;
            w_count_nxt = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= 5'd0;
            r_pc    <= 4'd0;
            r_instr <= 9'd0;
            r_pmode <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pmode <= pmode;
        end
    end

    // Store contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            r_mem[r_count[3:0]] <= prog_data;
        end
    end

    assign instout    = r_instr;
    assign inst_valid = (r_state == ISSUE);
    assign pc         = r_pc;
    assign prog_full  = (r_count == 5'd16);
    assign halt       = (r_state == HALT);

endmodule
